// File: rtl/bram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// bram_fifo_ctrl
//
// Turns an external 1024x16 dual-port block RAM into a first-word-fall-through
// ready/valid FIFO. RAM port A is write-only and port B is read-only. A
// 2-entry output buffer hides the RAM's one-cycle read latency, so the FIFO
// sustains one push and one pop per cycle.
//
// Ports
//   CLK          sole clock (the parent also drives RAM CLKA/CLKB from it)
//   reset        synchronous, active-high reset
//   push_valid   upstream word valid
//   push_data    upstream word
//   push_ready   controller can accept a word
//   pop_valid    head word valid
//   pop_data     head word
//   pop_ready    downstream accepts the head word
//   count        total occupancy: RAM words + in-flight read + buffered words
//   almost_full  RAM word count >= ALMOST_FULL_LVL
//   WEA/ENA      RAM port A write enable / enable
//   ADDRA/DIA    RAM write address / write data
//   ENB/ADDRB    RAM port B enable (read issue) / read address
//   DOB          RAM read data, valid the cycle after ENB
//
// Handshake: a word moves when valid and ready are both high at the rising
// edge of CLK. valid never depends on ready. push_ready depends only on
// registered state and reset, never on push_valid or pop_ready.
// ---------------------------------------------------------------------------
module bram_fifo_ctrl #(
    parameter int ADDR_BITS       = 10,
    parameter int DATA_BITS       = 16,
    parameter int ALMOST_FULL_LVL = 1000
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 push_valid,
    input  logic [DATA_BITS-1:0] push_data,
    output logic                 push_ready,
    output logic                 pop_valid,
    output logic [DATA_BITS-1:0] pop_data,
    input  logic                 pop_ready,
    output logic [ADDR_BITS+1:0] count,
    output logic                 almost_full,
    output logic                 WEA,
    output logic                 ENA,
    output logic [ADDR_BITS-1:0] ADDRA,
    output logic [DATA_BITS-1:0] DIA,
    output logic                 ENB,
    output logic [ADDR_BITS-1:0] ADDRB,
    input  logic [DATA_BITS-1:0] DOB
);

    localparam int                   DEPTH     = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0]   DEPTH_V   = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0]   AF_LVL    = (ADDR_BITS+1)'(ALMOST_FULL_LVL);
    localparam logic [ADDR_BITS+1:0] MAX_COUNT = (ADDR_BITS+2)'(DEPTH + 2);

    // Pointers carry one extra wrap bit so full (difference DEPTH) and
    // empty (difference 0) are distinguishable.
    logic [ADDR_BITS:0]   wr_ptr;
    logic [ADDR_BITS:0]   rd_ptr;
    logic                 rd_pend;
    logic [1:0]           obuf_cnt;
    logic [DATA_BITS-1:0] obuf [2];

    logic [ADDR_BITS:0]   ram_count;
    logic                 push_fire;
    logic                 pop_fire;
    logic                 issue;
    logic [1:0]           in_flight;
    logic [1:0]           cap_slot;
    logic                 cap_hi;

    always_comb begin
        ram_count  = wr_ptr - rd_ptr;
        push_ready = !reset && (ram_count != DEPTH_V);
        push_fire  = push_valid && push_ready;

        pop_valid  = (obuf_cnt != 2'd0);
        pop_data   = obuf[0];
        pop_fire   = pop_valid && pop_ready;

        // Words that will sit in the output buffer after this edge, counting
        // the read already in flight. Issue a new read only if it will fit.
        in_flight  = obuf_cnt + {1'b0, rd_pend} - {1'b0, pop_fire};
        issue      = !reset && (ram_count != '0) && (in_flight < 2'd2);

        // Returning read data lands just behind whatever survives this pop.
        cap_slot   = obuf_cnt - {1'b0, pop_fire};
        cap_hi     = (cap_slot != 2'd0);

        count       = {1'b0, ram_count}
                    + {{ADDR_BITS{1'b0}}, obuf_cnt}
                    + {{(ADDR_BITS+1){1'b0}}, rd_pend};
        almost_full = (ram_count >= AF_LVL);

        WEA   = push_fire;
        ENA   = push_fire;
        ADDRA = wr_ptr[ADDR_BITS-1:0];
        DIA   = push_data;
        ENB   = issue;
        ADDRB = rd_ptr[ADDR_BITS-1:0];
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_pend  <= 1'b0;
            obuf_cnt <= 2'd0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + (ADDR_BITS+1)'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + (ADDR_BITS+1)'(1);
            end
            rd_pend  <= issue;
            obuf_cnt <= in_flight;
            if (pop_fire) begin
                obuf[0] <= obuf[1];
            end
            // Placed after the shift so a capture into slot 0 during a pop
            // from a 1-entry buffer wins over the (stale) shifted value.
            if (rd_pend) begin
                obuf[cap_hi] <= DOB;
            end
        end
    end

    a_count_range: assert property (@(posedge CLK) disable iff (reset)
        count <= MAX_COUNT);

    a_capture_fits: assert property (@(posedge CLK) disable iff (reset)
        rd_pend |-> (cap_slot != 2'd2));

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bram_fifo_ctrl
//
// Bench for bram_fifo_ctrl with a behavioural RAM, a queue-based reference
// model checked every cycle, and directed sequences with literal expectations.
// ---------------------------------------------------------------------------
module tb_bram_fifo_ctrl;

    localparam int AB    = 10;
    localparam int DB    = 16;
    localparam int DEPTH = 1024;
    localparam int AF    = 1000;

    // ---------------- clock / reset / DUT ----------------
    logic          CLK = 1'b0;
    logic          reset;
    logic          push_valid;
    logic [DB-1:0] push_data;
    logic          push_ready;
    logic          pop_valid;
    logic [DB-1:0] pop_data;
    logic          pop_ready;
    logic [AB+1:0] count;
    logic          almost_full;
    logic          WEA;
    logic          ENA;
    logic [AB-1:0] ADDRA;
    logic [DB-1:0] DIA;
    logic          ENB;
    logic [AB-1:0] ADDRB;
    logic [DB-1:0] DOB;

    always #5 CLK = ~CLK;

    bram_fifo_ctrl #(
        .ADDR_BITS      (AB),
        .DATA_BITS      (DB),
        .ALMOST_FULL_LVL(AF)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .pop_ready  (pop_ready),
        .count      (count),
        .almost_full(almost_full),
        .WEA        (WEA),
        .ENA        (ENA),
        .ADDRA      (ADDRA),
        .DIA        (DIA),
        .ENB        (ENB),
        .ADDRB      (ADDRB),
        .DOB        (DOB)
    );

    // Behavioural block RAM: synchronous write on A, registered read on B.
    logic [DB-1:0] mem [DEPTH];
    always @(posedge CLK) begin
        if (ENA && WEA) mem[ADDRA] <= DIA;
        if (ENB) DOB <= mem[ADDRB];
    end

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // exp_q holds every stored word in FIFO order. The front n_obuf words are
    // in the output buffer, the next n_pend are being read, the rest in RAM.
    logic [DB-1:0] exp_q[$];
    int n_obuf = 0;
    int n_pend = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    bit model_valid = 0;

    always @(negedge CLK) begin
        int ram;
        bit e_pr, e_pv, pfire, ofire, e_iss;
        if (reset) begin
            chk("m_rst_push_ready", push_ready, 0);
            chk("m_rst_wea", WEA, 0);
            chk("m_rst_ena", ENA, 0);
            chk("m_rst_enb", ENB, 0);
            if (model_valid) begin
                chk("m_rst_pop_valid", pop_valid, (n_obuf > 0));
                chk("m_rst_count", count, exp_q.size());
            end
            exp_q.delete();
            n_obuf = 0;
            n_pend = 0;
            wr_cnt = 0;
            rd_cnt = 0;
            model_valid = 1;
        end else if (model_valid) begin
            ram   = exp_q.size() - n_obuf - n_pend;
            e_pr  = (ram != DEPTH);
            e_pv  = (n_obuf > 0);
            pfire = push_valid && e_pr;
            ofire = e_pv && pop_ready;
            e_iss = (ram != 0) && ((n_obuf + n_pend - int'(ofire)) < 2);

            chk("m_push_ready", push_ready, e_pr);
            chk("m_pop_valid", pop_valid, e_pv);
            chk("m_count", count, exp_q.size());
            chk("m_almost_full", almost_full, (ram >= AF));
            chk("m_wea", WEA, pfire);
            chk("m_ena", ENA, pfire);
            chk("m_enb", ENB, e_iss);
            if (e_pv)  chk("m_pop_data", pop_data, exp_q[0]);
            if (pfire) begin
                chk("m_addra", ADDRA, wr_cnt % DEPTH);
                chk("m_dia", DIA, push_data);
            end
            if (e_iss) chk("m_addrb", ADDRB, rd_cnt % DEPTH);

            if (ofire) begin
                void'(exp_q.pop_front());
                n_obuf--;
            end
            n_obuf += n_pend;
            n_pend  = int'(e_iss);
            if (e_iss) rd_cnt++;
            if (pfire) begin
                exp_q.push_back(push_data);
                wr_cnt++;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int acc;
        int got;
        bit pr_drop;
        bit have_held;
        bit found;
        logic [DB-1:0] held;

        reset      = 1'b1;
        push_valid = 1'b0;
        push_data  = '0;
        pop_ready  = 1'b0;

        // Reset then idle
        tick();
        tick();
        @(negedge CLK);
        chk("reset_push_ready", push_ready, 0);
        chk("reset_pop_valid", pop_valid, 0);
        chk("reset_wea", WEA, 0);
        chk("reset_enb", ENB, 0);
        tick();
        reset = 1'b0;
        @(negedge CLK);
        chk("release_push_ready", push_ready, 1);
        chk("release_count", count, 0);

        // Single word
        tick();
        pop_ready  = 1'b1;
        push_valid = 1'b1;
        push_data  = 16'hA5A5;
        @(negedge CLK);
        chk("single_wea", WEA, 1);
        chk("single_addra", ADDRA, 0);
        chk("single_dia", DIA, 16'hA5A5);
        tick();
        push_valid = 1'b0;
        @(negedge CLK);
        chk("single_enb", ENB, 1);
        chk("single_addrb", ADDRB, 0);
        tick();
        tick();
        @(negedge CLK);
        chk("single_pop_valid", pop_valid, 1);
        chk("single_pop_data", pop_data, 16'hA5A5);
        tick();
        @(negedge CLK);
        chk("single_count_after", count, 0);

        // Streaming 0..2047 with pop_ready held high
        got = 0;
        pr_drop = 0;
        for (int i = 0; i < 2048; i++) begin
            tick();
            push_valid = 1'b1;
            push_data  = 16'(i);
            @(negedge CLK);
            if (!push_ready) pr_drop = 1;
            if (pop_valid) begin
                chk("stream_data", pop_data, got);
                got++;
            end
        end
        tick();
        push_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (pop_valid) begin
                chk("stream_data", pop_data, got);
                got++;
            end
        end
        chk("stream_total", got, 2048);
        chk("stream_push_ready_drop", pr_drop, 0);

        // Fill with pop_ready low
        tick();
        pop_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 1040; i++) begin
            push_valid = 1'b1;
            push_data  = 16'h4000 + 16'(acc);
            @(negedge CLK);
            if (push_ready) acc++;
            tick();
        end
        push_data = 16'h4000 + 16'(acc);
        chk("fill_accepted", acc, 1026);
        @(negedge CLK);
        chk("fill_push_ready", push_ready, 0);
        chk("fill_count", count, 1026);
        chk("fill_almost_full", almost_full, 1);
        chk("fill_pop_valid", pop_valid, 1);
        tick();
        pop_ready = 1'b1;
        @(negedge CLK);
        chk("fill_pop_cycle_push_ready", push_ready, 0);
        chk("fill_pop_data", pop_data, 16'h4000);
        tick();
        pop_ready = 1'b0;
        @(negedge CLK);
        chk("fill_push_ready_reopens", push_ready, 1);
        tick();
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        got = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge CLK);
            if (pop_valid) begin
                chk("fill_drain_data", pop_data, 16'h4001 + 16'(got));
                got++;
            end
        end
        chk("fill_drain_total", got, 1026);
        chk("fill_drain_almost_full", almost_full, 0);

        // Backpressure: pop_ready cycles 1,0,0,1
        tick();
        acc = 0;
        got = 0;
        have_held = 0;
        held = '0;
        for (int c = 0; c < 200; c++) begin
            pop_ready = pat[c % 4];
            if (acc < 40) begin
                push_valid = 1'b1;
                push_data  = 16'h8000 + 16'(acc);
            end else begin
                push_valid = 1'b0;
            end
            @(negedge CLK);
            if (push_valid && push_ready) acc++;
            if (have_held) chk("bp_hold", pop_data, held);
            if (pop_valid && pop_ready) begin
                chk("bp_data", pop_data, 16'h8000 + 16'(got));
                got++;
            end
            have_held = pop_valid && !pop_ready;
            held = pop_data;
            tick();
        end
        chk("bp_total", got, 40);

        // Reset in the middle of a stream
        pop_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_valid = 1'b1;
            push_data  = 16'h9000 + 16'(i);
            tick();
        end
        reset = 1'b1;
        push_data = 16'h9006;
        @(negedge CLK);
        chk("midrst_push_ready", push_ready, 0);
        chk("midrst_wea", WEA, 0);
        chk("midrst_enb", ENB, 0);
        tick();
        reset = 1'b0;
        push_data = 16'h1234;
        @(negedge CLK);
        chk("midrst_pop_valid", pop_valid, 0);
        chk("midrst_count", count, 0);
        chk("midrst_push_ready_after", push_ready, 1);
        chk("midrst_wea_after", WEA, 1);
        chk("midrst_addra", ADDRA, 0);
        tick();
        push_data = 16'h5678;
        tick();
        push_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge CLK);
            if (pop_valid) begin
                chk("midrst_first_pop", pop_data, 16'h1234);
                found = 1;
            end
        end
        chk("midrst_pop_seen", found, 1);
        repeat (6) @(negedge CLK);
        chk("midrst_final_count", count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: time limit reached at t=%0t, expected completion earlier", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
